// File: rtl/jk_pkg.sv
// Shared encodings for the JK register bank: operating modes and per-cell JK pairs.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK     = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_LOAD   = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  // {j,k} pair as seen by a single cell
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_pair_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with async active-low reset, clock enable and synchronous clear.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic en,
  input  logic clr,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  logic r_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_q <= 1'b0;
    end else if (en) begin
      if (clr) begin
        r_q <= 1'b0;
      end else begin
        case ({j, k})
          JK_HOLD:   r_q <= r_q;
          JK_RESET:  r_q <= 1'b0;
          JK_SET:    r_q <= 1'b1;
          JK_TOGGLE: r_q <= ~r_q;
          default:   r_q <= r_q;
        endcase
      end
    end
  end

  // Derived from the same flop so qb can never lag q, including in reset.
  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: rtl/jk_reg_bank.sv
// Bank of JK cells; maps JK/TOGGLE/LOAD/COUNT modes onto per-cell (j,k) and
// builds the ripple-free count chain and terminal-count flag.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             up,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qb;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  // Toggle enable per bit: AND of all lower bits (up) or their complements (down).
  always_comb begin
    logic w_run;
    w_t   = '0;
    w_run = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_t[i] = w_run;
      w_run  = w_run & (up ? w_q[i] : ~w_q[i]);
    end
  end

  always_comb begin
    w_j = '0;
    w_k = '0;
    case (mode)
      MODE_JK: begin
        w_j = j;
        w_k = k;
      end
      MODE_TOGGLE: begin
        w_j = j;
        w_k = j;
      end
      MODE_LOAD: begin
        w_j = j;
        w_k = ~j;
      end
      MODE_COUNT: begin
        w_j = w_t;
        w_k = w_t;
      end
      default: begin
        w_j = '0;
        w_k = '0;
      end
    endcase
  end

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .rstb (rstb),
      .en   (en),
      .clr  (clr),
      .j    (w_j[g]),
      .k    (w_k[g]),
      .q    (w_q[g]),
      .qb   (w_qb[g])
    );
  end

  assign q  = w_q;
  assign qb = w_qb;
  assign tc = en & (mode == MODE_COUNT) & (up ? (&w_q) : ~(|w_q));

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank at WIDTH=4, 1 and 32.
module tb_jk_reg_bank;

  logic        clk = 1'b0;
  logic        rstb;
  logic        clr;
  logic [1:0]  mode;
  logic        up;

  logic        en4;
  logic [3:0]  j4, k4, q4, qb4;
  logic        tc4;

  logic        en1;
  logic [0:0]  j1, k1, q1, qb1;
  logic        tc1;

  logic        en32;
  logic [31:0] j32, k32, q32, qb32;
  logic        tc32;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rstb(rstb), .en(en4), .clr(clr), .mode(mode), .up(up),
    .j(j4), .k(k4), .q(q4), .qb(qb4), .tc(tc4)
  );

  jk_reg_bank #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rstb(rstb), .en(en1), .clr(clr), .mode(mode), .up(up),
    .j(j1), .k(k1), .q(q1), .qb(qb1), .tc(tc1)
  );

  jk_reg_bank #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rstb(rstb), .en(en32), .clr(clr), .mode(mode), .up(up),
    .j(j32), .k(k32), .q(q32), .qb(qb32), .tc(tc32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstb = 1'b0; clr = 1'b0; mode = 2'd0; up = 1'b1;
    en4 = 1'b0; j4 = '0; k4 = '0;
    en1 = 1'b0; j1 = '0; k1 = '0;
    en32 = 1'b0; j32 = '0; k32 = '0;
    #2;
    chk("rst_q4", {28'd0, q4}, 32'h0);
    chk("rst_qb4", {28'd0, qb4}, 32'hF);
    chk("rst_qb32", qb32, 32'hFFFF_FFFF);
    #10 rstb = 1'b1;

    // Count up from 0, then reset asynchronously in the middle of a cycle
    en4 = 1'b1; mode = 2'd3; up = 1'b1;
    step(); step(); step();
    chk("cnt_pre_rst", {28'd0, q4}, 32'h3);
    #2 rstb = 1'b0;
    #1;
    chk("async_rst_q", {28'd0, q4}, 32'h0);
    chk("async_rst_qb", {28'd0, qb4}, 32'hF);
    en4 = 1'b0;
    #3 rstb = 1'b1;
    step(); step();
    chk("post_rst_hold", {28'd0, q4}, 32'h0);

    // JK mode per-bit behaviour
    en4 = 1'b1; mode = 2'd2; j4 = 4'b1010;
    step();
    chk("load_a", {28'd0, q4}, 32'hA);
    mode = 2'd0; j4 = 4'b0110; k4 = 4'b0011;
    #1 chk("tc_jk_mode", {31'd0, tc4}, 32'h0);
    step();
    chk("jk_q", {28'd0, q4}, 32'hC);
    chk("jk_qb", {28'd0, qb4}, 32'h3);
    j4 = 4'b0000; k4 = 4'b0000;
    step();
    chk("jk_hold", {28'd0, q4}, 32'hC);

    // LOAD then TOGGLE then disabled
    mode = 2'd2; j4 = 4'h9; k4 = 4'h0;
    step();
    chk("load_9", {28'd0, q4}, 32'h9);
    mode = 2'd1; j4 = 4'hF;
    step();
    chk("toggle_6", {28'd0, q4}, 32'h6);
    en4 = 1'b0; clr = 1'b1; mode = 2'd3;
    step(); step(); step();
    chk("en_low_hold", {28'd0, q4}, 32'h6);
    clr = 1'b0;

    // COUNT up through wrap, then down
    en4 = 1'b1; mode = 2'd2; j4 = 4'hE;
    step();
    chk("load_e", {28'd0, q4}, 32'hE);
    mode = 2'd3; up = 1'b1;
    #1 chk("tc_at_e", {31'd0, tc4}, 32'h0);
    step();
    chk("cnt_f", {28'd0, q4}, 32'hF);
    chk("tc_at_f", {31'd0, tc4}, 32'h1);
    step();
    chk("cnt_wrap0", {28'd0, q4}, 32'h0);
    chk("tc_at_0_up", {31'd0, tc4}, 32'h0);
    up = 1'b0;
    #1 chk("tc_at_0_dn", {31'd0, tc4}, 32'h1);
    en4 = 1'b0;
    #1 chk("tc_en_low", {31'd0, tc4}, 32'h0);
    en4 = 1'b1;
    step();
    chk("cnt_dn_wrap", {28'd0, q4}, 32'hF);
    chk("tc_f_dn", {31'd0, tc4}, 32'h0);
    step();
    chk("cnt_dn_e", {28'd0, q4}, 32'hE);

    // clr priority over mode, and en over clr
    mode = 2'd2; j4 = 4'h7;
    step();
    mode = 2'd3; up = 1'b1; clr = 1'b1;
    step();
    chk("clr_cnt", {28'd0, q4}, 32'h0);
    clr = 1'b0; mode = 2'd2; j4 = 4'h5;
    step();
    en4 = 1'b0; clr = 1'b1;
    step();
    chk("clr_en_low", {28'd0, q4}, 32'h5);
    clr = 1'b0; en4 = 1'b1; mode = 2'd3; up = 1'b0;
    step();
    chk("cnt_dn_4", {28'd0, q4}, 32'h4);
    en4 = 1'b0;

    // WIDTH=1 count up
    mode = 2'd3; up = 1'b1; en1 = 1'b1;
    #1 chk("w1_tc0", {31'd0, tc1}, 32'h0);
    step();
    chk("w1_q1", {31'd0, q1}, 32'h1);
    chk("w1_tc1", {31'd0, tc1}, 32'h1);
    step();
    chk("w1_q0", {31'd0, q1}, 32'h0);
    chk("w1_qb", {31'd0, qb1}, 32'h1);
    en1 = 1'b0;

    // WIDTH=32 wrap
    en32 = 1'b1; mode = 2'd2; j32 = 32'hFFFF_FFFF;
    step();
    chk("w32_load", q32, 32'hFFFF_FFFF);
    chk("w32_qb_load", qb32, 32'h0);
    mode = 2'd3; up = 1'b1;
    #1 chk("w32_tc", {31'd0, tc32}, 32'h1);
    step();
    chk("w32_wrap", q32, 32'h0);
    chk("w32_qb_wrap", qb32, 32'hFFFF_FFFF);
    mode = 2'd2; j32 = 32'h0000_FFFF;
    step();
    mode = 2'd3;
    step();
    chk("w32_carry", q32, 32'h0001_0000);
    chk("w32_qb_carry", qb32, 32'hFFFE_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
